tage_table_bank: RTL
====================

Name: tage_table_bank

Overview:
Parametrised TAGE tagged-component table bank, the next generation of the per-bank controller. It holds DEPTH entries, each with a valid bit, partial tag, saturating prediction counter and usefulness counter. It provides a registered tag-compare lookup with a hit/prediction response and a single-port update path for train, allocate and useful adjustment. A background aging sweep halves or clears usefulness counters. One instance sits per tagged table in the branch predictor front-end.

Parameters:
DEPTH, 128, number of entries; power of two, >= AGELANES
IDXW, 7, index width, log2(DEPTH)
TAGW, 9, partial tag width
CTRW, 3, prediction counter width; MSB = taken
UW, 2, usefulness counter width
AGELANES, 4, entries aged per sweep cycle; divides DEPTH
AGEMODE, 0, 0 = useful >>= 1 on age; 1 = useful cleared to 0

Ports:
Clk  in  1  clock, rising edge
Rest  in  1  reset, asynchronous, active-low
LkValid  in  1  lookup request
LkIndex  in  IDXW  lookup entry index
LkTag  in  TAGW  lookup tag
RspValid  out  1  lookup response valid
RspHit  out  1  entry valid and tag matched
RspTaken  out  1  predicted direction (counter MSB), 0 when no hit
RspCtr  out  CTRW  counter value on hit, else 0
RspUseful  out  UW  useful value on hit, else 0
UpValid  in  1  update request
UpIndex  in  IDXW  update index
UpTag  in  TAGW  update tag
UpAlloc  in  1  allocate (overwrite) entry
UpTaken  in  1  resolved direction
UpUsefulInc  in  1  useful +1
UpUsefulDec  in  1  useful -1
AgeReq  in  1  start aging sweep (pulse)
AgeBusy  out  1  sweep in progress

Behaviour:
- Reset (Rest=0, asynchronous): every entry valid=0, tag=0, ctr=WNT=2^(CTRW-1)-1, useful=0. All outputs 0. FSM goes to IDLE and the sweep pointer is 0.
- Lookup: 1-cycle latency. LkValid at edge N gives RspValid=1 for the cycle after N, with results from the storage state before edge N. RspValid=0 in cycles without a request. No backpressure; a lookup is accepted every cycle.
- Hit = valid && stored tag == LkTag.
- Read-during-write: when a lookup and an update hit the same index in the same cycle, the response shows the old contents. The update is visible to lookups from the next cycle.
- Update, applied at the edge where UpValid=1:
  - UpAlloc=1: valid=1, tag=UpTag, ctr = WT (2^(CTRW-1)) if UpTaken else WNT, useful=0. The Inc/Dec inputs are ignored.
  - UpAlloc=0, entry valid and tag match: ctr saturating +1 if UpTaken else -1, clamped to 0 and 2^CTRW-1. Useful saturating +1 if only Inc is set, -1 if only Dec is set, unchanged if both or neither. Useful is clamped to 0 and 2^UW-1.
  - UpAlloc=0 with no match or invalid entry: no state change.
- Aging FSM:
  - States: IDLE and SWEEP.
  - IDLE: AgeReq=1 moves to SWEEP with ptr=0.
  - SWEEP: each cycle, entries ptr*AGELANES through ptr*AGELANES+AGELANES-1 get useful >>= 1 (AGEMODE=0) or useful = 0 (AGEMODE=1). ptr increments each cycle. After ptr = DEPTH/AGELANES-1 is processed, return to IDLE.
  - AgeBusy=1 exactly while in SWEEP, for DEPTH/AGELANES cycles. It is registered and rises the cycle after the AgeReq edge.
  - AgeReq is ignored while in SWEEP.
  - An update to an entry in the lane group being aged that same cycle has priority: that entry takes the update result and skips aging.
  - Lookups and updates continue normally during a sweep.
  - Valid, tag and ctr are never modified by aging.
- Reset asserted mid-sweep aborts immediately: AgeBusy=0 and all entries are re-initialised.
- Out-of-range indices cannot occur because DEPTH = 2^IDXW.

Test Plan:
(All scenarios use the default parameters, index 5, tag 0x1A5.)
1. Reset, then lookup idx 5 tag 0x1A5 -> next cycle RspValid=1, RspHit=0, RspTaken=0, RspCtr=0, RspUseful=0.
2. Training sequence, checked by lookup after each step:
   - Alloc idx 5 tag 0x1A5 UpTaken=1 -> RspHit=1, RspCtr=4, RspTaken=1, RspUseful=0.
   - 4 taken updates -> RspCtr saturates at 7.
   - 5 not-taken updates -> RspCtr=2, RspTaken=0.
3. Non-alloc update idx 5 tag 0x0A5 -> lookup with tag 0x1A5 unchanged (RspCtr=2); lookup with tag 0x0A5 gives RspHit=0.
4. Useful and aging:
   - 4×UpUsefulInc on idx 5 -> RspUseful=3 (saturated).
   - Inc+Dec in the same update -> RspUseful stays 3.
   - AgeReq -> AgeBusy high exactly 32 cycles, then RspUseful=1.
   - Second AgeReq mid-sweep does not extend AgeBusy.
   - AGEMODE=1 build: the same sequence ends with RspUseful=0.
5. Same-cycle lookup and taken update on idx 5 with RspCtr=2 -> response RspCtr=2; following lookup gives 3. Also, during a sweep, an UpUsefulInc on idx 5 in its aging cycle -> useful = old+1, not halved.
6. Assert Rest=0 at sweep cycle 10, asynchronously between edges -> AgeBusy=0 and RspValid=0 immediately. After release, lookup idx 5 gives RspHit=0 and AgeReq starts a full 32-cycle sweep.

Source files
------------

// File: rtl/tage_table_bank.sv
// TAGE tagged-component table bank.
// DEPTH entries of {valid, partial tag, prediction counter, usefulness
// counter} with a registered tag-compare lookup, a single-port
// train/allocate/useful update path and a background aging sweep that
// halves (AGEMODE=0) or clears (AGEMODE=1) the usefulness counters.
module tage_table_bank #(
  parameter int DEPTH    = 128,
  parameter int IDXW     = 7,
  parameter int TAGW     = 9,
  parameter int CTRW     = 3,
  parameter int UW       = 2,
  parameter int AGELANES = 4,
  parameter int AGEMODE  = 0
) (
  input  logic            Clk,
  input  logic            Rest,
  input  logic            LkValid,
  input  logic [IDXW-1:0] LkIndex,
  input  logic [TAGW-1:0] LkTag,
  output logic            RspValid,
  output logic            RspHit,
  output logic            RspTaken,
  output logic [CTRW-1:0] RspCtr,
  output logic [UW-1:0]   RspUseful,
  input  logic            UpValid,
  input  logic [IDXW-1:0] UpIndex,
  input  logic [TAGW-1:0] UpTag,
  input  logic            UpAlloc,
  input  logic            UpTaken,
  input  logic            UpUsefulInc,
  input  logic            UpUsefulDec,
  input  logic            AgeReq,
  output logic            AgeBusy
);

  localparam int GROUPS = DEPTH / AGELANES;
  localparam int PTRW   = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  // Weakly-not-taken / weakly-taken counter values around the MSB boundary.
  localparam logic [CTRW-1:0] CTR_WNT  = CTRW'((1 << (CTRW - 1)) - 1);
  localparam logic [CTRW-1:0] CTR_WT   = CTRW'(1 << (CTRW - 1));
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(GROUPS - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  // Saturating train of the prediction counter toward the resolved direction.
  function automatic logic [CTRW-1:0] ctr_train(input logic [CTRW-1:0] c, input logic taken);
    logic [CTRW-1:0] r;
    if (taken) begin
      r = (&c) ? c : c + CTRW'(1);
    end else begin
      r = (c == CTRW'(0)) ? c : c - CTRW'(1);
    end
    return r;
  endfunction

  // Saturating usefulness adjust; Inc and Dec together cancel out.
  function automatic logic [UW-1:0] useful_adj(input logic [UW-1:0] u, input logic inc,
                                               input logic dec);
    logic [UW-1:0] r;
    case ({inc, dec})
      2'b10:   r = (&u) ? u : u + UW'(1);
      2'b01:   r = (u == UW'(0)) ? u : u - UW'(1);
      default: r = u;
    endcase
    return r;
  endfunction

  // Aging transform applied to one usefulness counter.
  function automatic logic [UW-1:0] useful_age(input logic [UW-1:0] u);
    logic [UW-1:0] r;
    if (AGEMODE != 0) begin
      r = UW'(0);
    end else begin
      r = u >> 1;
    end
    return r;
  endfunction

  logic            valid_r  [DEPTH];
  logic [TAGW-1:0] tag_r    [DEPTH];
  logic [CTRW-1:0] ctr_r    [DEPTH];
  logic [UW-1:0]   useful_r [DEPTH];

  logic [0:0]      state_r;
  logic [PTRW-1:0] ptr_r;

  logic            lk_hit_s;
  logic [CTRW-1:0] lk_ctr_s;
  logic [UW-1:0]   lk_useful_s;
  logic            up_match_s;
  logic            sweep_s;

  assign sweep_s    = (state_r == ST_SWEEP);
  assign up_match_s = valid_r[UpIndex] && (tag_r[UpIndex] == UpTag);
  assign AgeBusy    = sweep_s;

  // Tag compare on the pre-edge storage contents; fields are zero on a miss.
  always_comb begin
    lk_hit_s    = 1'b0;
    lk_ctr_s    = CTRW'(0);
    lk_useful_s = UW'(0);
    if (valid_r[LkIndex] && (tag_r[LkIndex] == LkTag)) begin
      lk_hit_s    = 1'b1;
      lk_ctr_s    = ctr_r[LkIndex];
      lk_useful_s = useful_r[LkIndex];
    end else begin
      lk_hit_s    = 1'b0;
    end
  end

  // Register the lookup response one cycle after the request.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      RspValid  <= 1'b0;
      RspHit    <= 1'b0;
      RspTaken  <= 1'b0;
      RspCtr    <= CTRW'(0);
      RspUseful <= UW'(0);
    end else if (LkValid) begin
      RspValid  <= 1'b1;
      RspHit    <= lk_hit_s;
      RspTaken  <= lk_ctr_s[CTRW-1];
      RspCtr    <= lk_ctr_s;
      RspUseful <= lk_useful_s;
    end else begin
      RspValid  <= 1'b0;
      RspHit    <= 1'b0;
      RspTaken  <= 1'b0;
      RspCtr    <= CTRW'(0);
      RspUseful <= UW'(0);
    end
  end

  // Aging sequencer: one lane group per cycle, new requests ignored mid-sweep.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_r <= ST_IDLE;
      ptr_r   <= PTRW'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (AgeReq) begin
            state_r <= ST_SWEEP;
          end
          ptr_r <= PTRW'(0);
        end
        ST_SWEEP: begin
          if (ptr_r == PTR_LAST) begin
            state_r <= ST_IDLE;
            ptr_r   <= PTRW'(0);
          end else begin
            ptr_r   <= ptr_r + PTRW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ptr_r   <= PTRW'(0);
        end
      endcase
    end
  end

  // Entry storage: an update addressed to an entry takes priority over its aging.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= TAGW'(0);
        ctr_r[i]    <= CTR_WNT;
        useful_r[i] <= UW'(0);
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (UpValid && (UpIndex == IDXW'(i))) begin
          if (UpAlloc) begin
            valid_r[i]  <= 1'b1;
            tag_r[i]    <= UpTag;
            ctr_r[i]    <= UpTaken ? CTR_WT : CTR_WNT;
            useful_r[i] <= UW'(0);
          end else if (up_match_s) begin
            ctr_r[i]    <= ctr_train(ctr_r[i], UpTaken);
            useful_r[i] <= useful_adj(useful_r[i], UpUsefulInc, UpUsefulDec);
          end
        end else if (sweep_s && ((i / AGELANES) == int'(ptr_r))) begin
          useful_r[i] <= useful_age(useful_r[i]);
        end
      end
    end
  end

endmodule
